tri_raster_scan_ctrl: RTL and testbench
=======================================

TRI_RASTER_SCAN_CTRL -- requirements
Module: tri_raster_scan_ctrl

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, default 100: number of pixel columns; valid x is 0..DISPLAY_WIDTH-1.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, default 100: number of pixel rows; valid y is 0..DISPLAY_HEIGHT-1.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_tri  input  int_triangle  vertices a, b, c; each x and y is a signed 32-bit integer.
REQ-007 tri_valid  input  1  in_tri is valid.
REQ-008 tri_ready  output  1  block accepts a triangle this cycle.
REQ-009 pix_x  output  32 (signed)  current pixel column.
REQ-010 pix_y  output  32 (signed)  current pixel row.
REQ-011 pix_valid  output  1  pix_x/pix_y are valid.
REQ-012 pix_ready  input  1  downstream consumes the pixel this cycle.
REQ-013 pix_last  output  1  current pixel is the last pixel of the triangle.
REQ-014 busy  output  1  a triangle is in progress (state is not IDLE).
REQ-015 done  output  1  one-cycle pulse at the end of each accepted triangle.

Function
REQ-016 SHALL implement the states IDLE, SETUP, SCAN and DONE.
REQ-017 IDLE: tri_ready=1; a triangle is accepted when tri_valid and tri_ready are both 1; on acceptance, in_tri SHALL be registered and the state SHALL go to SETUP.
REQ-018 SETUP: the block SHALL register the clamped bounding box. bx0=max(0, min(a.x,b.x,c.x)); bx1=min(DISPLAY_WIDTH-1, max(a.x,b.x,c.x)). by0 and by1 use the same rules on y with DISPLAY_HEIGHT. All comparisons are signed 32-bit.
REQ-019 SETUP exit: if bx0>bx1 or by0>by1 (empty box), the state SHALL go to DONE; otherwise pix_x=bx0, pix_y=by0, and the state SHALL go to SCAN.
REQ-020 Latency: with acceptance at cycle N, the first pix_valid SHALL occur at cycle N+2. For an empty box, done SHALL occur at cycle N+2.
REQ-021 SCAN: pix_valid=1. pix_x, pix_y and pix_last SHALL hold stable while pix_ready=0.
REQ-022 Scan order is row-major. On a handshake (pix_valid and pix_ready):
  - if pix_x<bx1: pix_x increments;
  - otherwise pix_x returns to bx0 and pix_y increments.
REQ-023 pix_last SHALL be 1 exactly when pix_x==bx1 and pix_y==by1. A handshake on the last pixel SHALL move the state to DONE on the next cycle.
REQ-024 DONE: done=1 for exactly one cycle, pix_valid=0, then the state SHALL return to IDLE.
REQ-025 tri_ready SHALL be 0 in SETUP, SCAN and DONE; tri_valid is ignored outside IDLE.
REQ-026 The next triangle SHALL be acceptable no earlier than the cycle after done.
REQ-027 pix_valid SHALL be 0 in all states other than SCAN.
REQ-028 Degenerate triangles (collinear or coincident vertices) SHALL be scanned as their bounding box; no special case applies.
REQ-029 The pixel count per triangle SHALL equal (bx1-bx0+1)*(by1-by0+1), with no duplicated or skipped pixels.

Reset
REQ-030 When rst_n=0 at a clock edge, the state SHALL go to IDLE and all outputs SHALL be forced to their reset values, including in mid-SCAN or DONE. No done pulse is generated for an aborted triangle.
REQ-031 Reset values: tri_ready=1 (the cycle after reset deasserts), pix_valid=0, pix_last=0, pix_x=0, pix_y=0, busy=0, done=0.

Verification
REQ-032 Basic scan, pix_ready=1: accept tri (2,3),(4,3),(3,5) at cycle N -> 9 pixels in order (2,3),(3,3),(4,3),(2,4) ... (4,5) in cycles N+2..N+10; pix_last only on (4,5); done at N+11; tri_ready=1 at N+12.
REQ-033 Backpressure: same triangle with pix_ready random (~50%) -> identical 9-pixel sequence; outputs stable on every stalled cycle; exactly one done.
REQ-034 Off-screen triangle: (-10,-10),(-5,-8),(-7,-2) accepted at N -> no pix_valid; done at N+2; busy=1 for N+1..N+2.
REQ-035 Clipping with W=H=100: (-3,98),(2,105),(0,99) -> box x 0..2, y 98..99; 6 pixels ending with (2,99) and pix_last=1.
REQ-036 Single pixel: (7,7),(7,7),(7,7) -> one pixel (7,7) with pix_last=1; then done.
REQ-037 Reset mid-scan: drop rst_n to 0 for one cycle during the 4th pixel of REQ-032 -> next cycle pix_valid=0, busy=0, done=0, state IDLE; a new triangle is then accepted and scanned correctly from its first pixel.

Source files
------------

// File: rtl/tri_raster_scan_ctrl.sv
// Triangle bounding-box raster scan controller: accepts a triangle, clamps its
// bounding box to the display, then emits every pixel of the box in row-major order.
package tri_raster_pkg;
  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } int_point;

  typedef struct packed {
    int_point a;
    int_point b;
    int_point c;
  } int_triangle;
endpackage

module tri_raster_scan_ctrl
  import tri_raster_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 100,
  parameter int DISPLAY_HEIGHT = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  int_triangle        in_tri,
  input  logic               tri_valid,
  output logic               tri_ready,
  output logic signed [31:0] pix_x,
  output logic signed [31:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  localparam logic signed [31:0] XMAX = 32'(DISPLAY_WIDTH - 1);
  localparam logic signed [31:0] YMAX = 32'(DISPLAY_HEIGHT - 1);

  state_t             state_q, state_d;
  int_triangle        tri_q, tri_d;
  logic signed [31:0] bx0_q, bx0_d, bx1_q, bx1_d;
  logic signed [31:0] by0_q, by0_d, by1_q, by1_d;
  logic signed [31:0] px_q, px_d, py_q, py_d;

  logic signed [31:0] min_x, max_x, min_y, max_y;
  logic signed [31:0] set_x0, set_x1, set_y0, set_y1;
  logic               box_empty;
  logic               at_last;

  function automatic logic signed [31:0] min3(input logic signed [31:0] p,
                                              input logic signed [31:0] q,
                                              input logic signed [31:0] r);
    logic signed [31:0] m;
    m = (p < q) ? p : q;
    return (r < m) ? r : m;
  endfunction

  function automatic logic signed [31:0] max3(input logic signed [31:0] p,
                                              input logic signed [31:0] q,
                                              input logic signed [31:0] r);
    logic signed [31:0] m;
    m = (p > q) ? p : q;
    return (r > m) ? r : m;
  endfunction

  // Clamped bounding box of the registered triangle, consumed only in SETUP.
  always_comb begin
    min_x     = min3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
    max_x     = max3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
    min_y     = min3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
    max_y     = max3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
    set_x0    = (min_x < 0)    ? '0   : min_x;
    set_x1    = (max_x > XMAX) ? XMAX : max_x;
    set_y0    = (min_y < 0)    ? '0   : min_y;
    set_y1    = (max_y > YMAX) ? YMAX : max_y;
    box_empty = (set_x0 > set_x1) || (set_y0 > set_y1);
  end

  assign at_last = (px_q == bx1_q) && (py_q == by1_q);

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    bx0_d   = bx0_q;
    bx1_d   = bx1_q;
    by0_d   = by0_q;
    by1_d   = by1_q;
    px_d    = px_q;
    py_d    = py_q;
    case (state_q)
      IDLE: begin
        if (tri_valid) begin
          tri_d   = in_tri;
          state_d = SETUP;
        end
      end
      SETUP: begin
        bx0_d = set_x0;
        bx1_d = set_x1;
        by0_d = set_y0;
        by1_d = set_y1;
        if (box_empty) begin
          state_d = DONE;
        end else begin
          px_d    = set_x0;
          py_d    = set_y0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pix_ready) begin
          if (at_last) begin
            state_d = DONE;
          end else if (px_q < bx1_q) begin
            px_d = px_q + 32'sd1;
          end else begin
            px_d = bx0_q;
            py_d = py_q + 32'sd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tri_q   <= '0;
      bx0_q   <= '0;
      bx1_q   <= '0;
      by0_q   <= '0;
      by1_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      bx0_q   <= bx0_d;
      bx1_q   <= bx1_d;
      by0_q   <= by0_d;
      by1_q   <= by1_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign tri_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pix_valid = (state_q == SCAN);
  assign pix_last  = (state_q == SCAN) && at_last;
  assign pix_x     = px_q;
  assign pix_y     = py_q;

endmodule

// File: tb/tb_tri_raster_scan_ctrl.sv
// Randomized scoreboard bench for tri_raster_scan_ctrl: a box model queues the
// expected pixel/done stream and a monitor compares it against the DUT output.
module tb_tri_raster_scan_ctrl;
  import tri_raster_pkg::*;

  localparam int W = 100;
  localparam int H = 100;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  int_triangle        in_tri = '0;
  logic               tri_valid = 1'b0;
  logic               tri_ready;
  logic signed [31:0] pix_x, pix_y;
  logic               pix_valid;
  logic               pix_ready = 1'b1;
  logic               pix_last, busy, done;

  tri_raster_scan_ctrl #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_tri(in_tri), .tri_valid(tri_valid),
    .tri_ready(tri_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit bp = 1'b0;

  typedef struct {
    bit is_done;
    int x;
    int y;
    bit last;
  } ev_t;
  typedef struct {
    int acc;
    bit empty;
  } trec_t;

  ev_t   exp_q[$];
  trec_t trec_q[$];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int_triangle mk(input int ax, input int ay, input int bx,
                                     input int by, input int cx, input int cy);
    int_triangle t;
    t.a.x = ax; t.a.y = ay;
    t.b.x = bx; t.b.y = by;
    t.c.x = cx; t.c.y = cy;
    return t;
  endfunction

  // Reference: every pixel of the display-clipped bounding box, rows then columns.
  function automatic void model(input int_triangle t, input int acc);
    int xs[3];
    int ys[3];
    int x0, x1, y0, y1;
    bit empty;
    xs[0] = t.a.x; xs[1] = t.b.x; xs[2] = t.c.x;
    ys[0] = t.a.y; ys[1] = t.b.y; ys[2] = t.c.y;
    x0 = xs[0]; x1 = xs[0]; y0 = ys[0]; y1 = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < x0) x0 = xs[i];
      if (xs[i] > x1) x1 = xs[i];
      if (ys[i] < y0) y0 = ys[i];
      if (ys[i] > y1) y1 = ys[i];
    end
    if (x0 < 0) x0 = 0;
    if (y0 < 0) y0 = 0;
    if (x1 > W - 1) x1 = W - 1;
    if (y1 > H - 1) y1 = H - 1;
    empty = (x0 > x1) || (y0 > y1);
    if (!empty)
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++)
          exp_q.push_back('{1'b0, x, y, (x == x1) && (y == y1)});
    exp_q.push_back('{1'b1, 0, 0, 1'b0});
    trec_q.push_back('{acc, empty});
  endfunction

  task automatic send(input int_triangle t, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(posedge clk); #1;
    in_tri = t;
    tri_valid = 1'b1;
    while (n < 2000) begin
      @(negedge clk);
      if (tri_ready) begin
        acc = cyc;
        model(t, acc);
        break;
      end
      n++;
    end
    if (acc < 0) fail_now("accept_timeout");
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    dc = -1;
    while (n < 5000) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
      n++;
    end
    if (dc < 0) fail_now("done_timeout");
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and every done pulse.
  initial begin
    bit    started;
    bit    hold;
    int    hx, hy;
    bit    hl;
    int    last_hs;
    ev_t   e;
    trec_t r;
    started = 0; hold = 0; hx = 0; hy = 0; hl = 0; last_hs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        started = 0;
        hold = 0;
        continue;
      end
      chk("valid_implies_busy", longint'(pix_valid && !busy), 0);
      chk("ready_iff_idle", longint'(tri_ready), longint'(!busy));
      chk("done_no_valid", longint'(done && pix_valid), 0);
      if (pix_valid) begin
        if (!started) begin
          started = 1;
          if (trec_q.size() == 0) fail_now("unexpected_pixel");
          else chk("first_pix_latency", cyc, trec_q[0].acc + 2);
        end
        if (hold) begin
          chk("stall_x", pix_x, hx);
          chk("stall_y", pix_y, hy);
          chk("stall_last", longint'(pix_last), longint'(hl));
        end
        if (pix_ready) begin
          hold = 0;
          last_hs = cyc;
          if (exp_q.size() == 0) fail_now("extra_pixel");
          else begin
            e = exp_q.pop_front();
            chk("pix_not_done", longint'(e.is_done), 0);
            if (!e.is_done) begin
              chk("pix_x", pix_x, e.x);
              chk("pix_y", pix_y, e.y);
              chk("pix_last", longint'(pix_last), longint'(e.last));
            end
          end
        end else begin
          hold = 1;
          hx = pix_x;
          hy = pix_y;
          hl = pix_last;
        end
      end
      if (done) begin
        if (exp_q.size() == 0 || trec_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = exp_q.pop_front();
          chk("done_after_all_pixels", longint'(e.is_done), 1);
          r = trec_q.pop_front();
          chk("done_latency", cyc, r.empty ? r.acc + 2 : last_hs + 1);
        end
        started = 0;
        hold = 0;
      end
    end
  end

  initial begin
    int acc, dc, n, cx, cy;
    int_triangle t1;
    t1 = mk(2, 3, 4, 3, 3, 5);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tri_ready", longint'(tri_ready), 1);
    chk("rst_pix_valid", longint'(pix_valid), 0);
    chk("rst_pix_last", longint'(pix_last), 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);

    send(t1, acc);
    wait_done(dc);
    chk("basic_done_cycle", dc, acc + 11);
    @(negedge clk);
    chk("basic_ready_after_done", longint'(tri_ready), 1);

    bp = 1'b1;
    send(t1, acc);
    wait_done(dc);
    bp = 1'b0;

    send(mk(-10, -10, -5, -8, -7, -2), acc);
    @(negedge clk);
    chk("offscreen_busy", longint'(busy), 1);
    chk("offscreen_no_valid", longint'(pix_valid), 0);
    wait_done(dc);
    chk("offscreen_done_cycle", dc, acc + 2);

    send(mk(-3, 98, 2, 105, 0, 99), acc);
    wait_done(dc);
    send(mk(7, 7, 7, 7, 7, 7), acc);
    wait_done(dc);
    send(mk(0, 50, 99, 50, 40, 50), acc);
    wait_done(dc);

    // Reset lands while the 4th pixel of t1 is presented.
    send(t1, acc);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    trec_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_pix_valid", longint'(pix_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_tri_ready", longint'(tri_ready), 1);
    chk("midrst_pix_x", pix_x, 0);
    send(t1, acc);
    wait_done(dc);

    for (int k = 0; k < 40; k++) begin
      bp = 1'($urandom_range(0, 1));
      cx = int'($urandom_range(0, 130)) - 15;
      cy = int'($urandom_range(0, 130)) - 15;
      send(mk(cx + int'($urandom_range(0, 12)) - 6, cy + int'($urandom_range(0, 12)) - 6,
              cx + int'($urandom_range(0, 12)) - 6, cy + int'($urandom_range(0, 12)) - 6,
              cx + int'($urandom_range(0, 12)) - 6, cy + int'($urandom_range(0, 12)) - 6),
           acc);
      if ($urandom_range(0, 3) != 0) wait_done(dc);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
